// File: rtl/filter_median_pkg.sv
// Shared constants and elaboration helpers for the k x k median filter.
package filter_median_pkg;

  localparam int unsigned L = 4;

  function automatic bit win_legal(input int unsigned win);
    return (win == 3) || (win == 5);
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned rank_w(input int unsigned win);
    return clog2(win * win);
  endfunction

endpackage

// File: rtl/median_rank_sel.sv
// Rank-based median of N samples: registered pairwise compare, registered rank sum,
// combinational one-hot select of the element whose rank is (N-1)/2.
module median_rank_sel
  import filter_median_pkg::*;
#(
  parameter int unsigned N  = 25,
  parameter int unsigned PW = 8,
  parameter int unsigned RW = clog2(25)
)(
  input  logic            clk,
  input  logic            i_en_cmp,
  input  logic            i_en_rank,
  input  logic [N*PW-1:0] i_win,
  output logic [PW-1:0]   o_med
);

  localparam int unsigned MID = (N - 1) / 2;

  logic [N-1:0]    r_cmp [N];
  logic [N*PW-1:0] r_val_c;
  logic [N*PW-1:0] r_val_r;
  logic [RW-1:0]   r_rank [N];
  logic [RW-1:0]   w_rank [N];

  // Ties are broken by index so every rank is unique and exactly one element matches MID.
  always_ff @(posedge clk) begin
    if (i_en_cmp) begin
      r_val_c <= i_win;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          r_cmp[i][j] <= (i_win[j*PW +: PW] < i_win[i*PW +: PW]) ||
                         ((j < i) && (i_win[j*PW +: PW] == i_win[i*PW +: PW]));
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_rank[i] = '0;
      for (int unsigned j = 0; j < N; j++) begin
        w_rank[i] = w_rank[i] + RW'(r_cmp[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_en_rank) begin
      r_val_r <= r_val_c;
      for (int unsigned i = 0; i < N; i++) r_rank[i] <= w_rank[i];
    end
  end

  always_comb begin
    o_med = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_rank[i] == RW'(MID)) o_med = o_med | r_val_r[i*PW +: PW];
    end
  end

endmodule

// File: rtl/filter_median_kxk.sv
// Streaming WIN x WIN median filter with line buffers, per-frame bypass latch and
// fixed 4-cycle latency (window, compare, rank, select).
module filter_median_kxk
  import filter_median_pkg::*;
#(
  parameter int unsigned WIN           = 5,
  parameter int unsigned CH_COUNT      = 1,
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned LINE_SIZE_MAX = 4096
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bypass,
  input  logic [CH_COUNT*PIXEL_WIDTH-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [CH_COUNT*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic [CH_COUNT*PIXEL_WIDTH-1:0] bypass_o
);

  localparam int unsigned DW = CH_COUNT * PIXEL_WIDTH;
  localparam int unsigned N  = WIN * WIN;
  localparam int unsigned RW = rank_w(WIN);
  localparam int unsigned C  = (WIN - 1) / 2;
  localparam int unsigned XW = clog2(LINE_SIZE_MAX + 1);
  localparam int unsigned AW = (LINE_SIZE_MAX > 1) ? clog2(LINE_SIZE_MAX) : 1;
  localparam int unsigned YW = 16;

  if (!win_legal(WIN)) begin : g_bad_win
    $error("filter_median_kxk: WIN must be 3 or 5");
  end

  logic [DW-1:0] r_lb [WIN-1][LINE_SIZE_MAX];
  logic [DW-1:0] r_win [WIN][WIN];
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_hs_d, r_vs_d, r_line_de, r_armed, r_byp;
  logic          r_v1, r_v2, r_v3;
  logic [DW-1:0] r_cen2, r_cen3;
  logic [L-1:0]  r_hs_pipe, r_vs_pipe;
  logic [AW-1:0] w_addr;
  logic          w_push, w_out_ok, w_hs_rise, w_vs_rise;
  logic [DW-1:0] w_med;

  assign w_addr    = r_x[AW-1:0];
  assign w_push    = de_i && (r_x < XW'(LINE_SIZE_MAX));
  assign w_hs_rise = hs_i && !r_hs_d;
  assign w_vs_rise = vs_i && !r_vs_d;
  assign w_out_ok  = w_push && r_armed && (r_x >= XW'(WIN - 1)) && (r_y >= YW'(WIN - 1));

  // r_vs_d resets high so a reset inside an active frame cannot fake a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_hs_d    <= 1'b0;
      r_vs_d    <= 1'b1;
      r_line_de <= 1'b0;
      r_armed   <= 1'b0;
      r_byp     <= 1'b0;
    end else begin
      r_hs_d <= hs_i;
      r_vs_d <= vs_i;
      if (hs_i)        r_x <= '0;
      else if (w_push) r_x <= r_x + XW'(1);
      if (!vs_i) begin
        r_y       <= '0;
        r_line_de <= 1'b0;
      end else if (w_hs_rise) begin
        if (r_line_de && (r_y != '1)) r_y <= r_y + YW'(1);
        r_line_de <= 1'b0;
      end else if (de_i) begin
        r_line_de <= 1'b1;
      end
      if (w_vs_rise) begin
        r_armed <= 1'b1;
        r_byp   <= bypass;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lb[0][w_addr] <= di_i;
      for (int unsigned r = 1; r < WIN - 1; r++) r_lb[r][w_addr] <= r_lb[r-1][w_addr];
    end
  end

  // r_win[col][row]: col WIN-1 is the newest pixel, row 0 the current line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < WIN; c++)
        for (int unsigned r = 0; r < WIN; r++) r_win[c][r] <= '0;
    end else if (w_push) begin
      for (int unsigned c = 0; c < WIN - 1; c++)
        for (int unsigned r = 0; r < WIN; r++) r_win[c][r] <= r_win[c+1][r];
      r_win[WIN-1][0] <= di_i;
      for (int unsigned r = 1; r < WIN; r++) r_win[WIN-1][r] <= r_lb[r-1][w_addr];
    end
  end

  for (genvar ch = 0; ch < CH_COUNT; ch++) begin : g_ch
    logic [N*PIXEL_WIDTH-1:0] w_flat;
    always_comb begin
      w_flat = '0;
      for (int unsigned c = 0; c < WIN; c++)
        for (int unsigned r = 0; r < WIN; r++)
          w_flat[(c*WIN + r)*PIXEL_WIDTH +: PIXEL_WIDTH] = r_win[c][r][ch*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
    median_rank_sel #(.N(N), .PW(PIXEL_WIDTH), .RW(RW)) u_sel (
      .clk       (clk),
      .i_en_cmp  (r_v1),
      .i_en_rank (r_v2),
      .i_win     (w_flat),
      .o_med     (w_med[ch*PIXEL_WIDTH +: PIXEL_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_cen2    <= '0;
      r_cen3    <= '0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
      de_o      <= 1'b0;
      do_o      <= '0;
      bypass_o  <= '0;
    end else begin
      r_v1      <= w_out_ok;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      de_o      <= r_v3;
      r_hs_pipe <= {r_hs_pipe[L-2:0], hs_i};
      r_vs_pipe <= {r_vs_pipe[L-2:0], vs_i};
      if (r_v1) r_cen2 <= r_win[C][C];
      if (r_v2) r_cen3 <= r_cen2;
      if (r_v3) begin
        bypass_o <= r_cen3;
        do_o     <= r_byp ? r_cen3 : w_med;
      end
    end
  end

  assign hs_o = r_hs_pipe[L-1];
  assign vs_o = r_vs_pipe[L-1];

endmodule

// File: tb/tb_filter_median_kxk.sv
// Frame-table bench for filter_median_kxk: WIN=5 and WIN=3 instances share one
// stimulus stream; a sorting reference model feeds per-instance scoreboards.
module tb_filter_median_kxk;

  localparam int unsigned CH  = 3;
  localparam int unsigned PW  = 8;
  localparam int unsigned DW  = CH * PW;
  localparam int unsigned LSM = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, bypass, de_i, hs_i, vs_i;
  logic [DW-1:0] di_i;
  logic [DW-1:0] do5, byp5, do3, byp3;
  logic          de5, hs5, vs5, de3, hs3, vs3;

  filter_median_kxk #(.WIN(5), .CH_COUNT(CH), .PIXEL_WIDTH(PW), .LINE_SIZE_MAX(LSM)) u_dut5 (
    .clk(clk), .rst(rst), .bypass(bypass), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do5), .de_o(de5), .hs_o(hs5), .vs_o(vs5), .bypass_o(byp5)
  );

  filter_median_kxk #(.WIN(3), .CH_COUNT(CH), .PIXEL_WIDTH(PW), .LINE_SIZE_MAX(LSM)) u_dut3 (
    .clk(clk), .rst(rst), .bypass(bypass), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do3), .de_o(de3), .hs_o(hs3), .vs_o(vs3), .bypass_o(byp3)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] b;
    int unsigned   cyc;
  } exp_t;

  typedef struct {
    int pat;
    int w;
    int h;
    int gap;
    bit byp;
    int rst_row;
    int exp5;
    int exp3;
  } frame_t;

  exp_t          q5[$];
  exp_t          q3[$];
  exp_t          e5, e3;
  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   cyc      = 0;
  int unsigned   cnt5     = 0;
  int unsigned   cnt3     = 0;
  logic [DW-1:0] img [48][70];
  logic [3:0]    hs_h = '0;
  logic [3:0]    vs_h = '0;
  bit            mon_en  = 1'b0;
  bit            no_push = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int pat, input int x, input int y);
    logic [PW-1:0] b, g, r;
    case (pat)
      0: begin b = 8'd100; g = 8'd100; r = 8'd100; end
      1: begin
        b = (x == 20 && y == 20) ? 8'd255 : 8'd0;
        g = b;
        r = b;
      end
      2: begin b = 8'(x); g = 8'(y); r = 8'(255 - x); end
      default: {r, g, b} = 24'($urandom);
    endcase
    return {r, g, b};
  endfunction

  function automatic logic [DW-1:0] med(input int x, input int y, input int win);
    logic [PW-1:0] v[25];
    logic [PW-1:0] t;
    logic [DW-1:0] res;
    int n, j;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      n = 0;
      for (int dy = 0; dy < win; dy++)
        for (int dx = 0; dx < win; dx++) begin
          v[n] = img[y-dy][x-dx][ch*PW +: PW];
          n++;
        end
      for (int i = 1; i < n; i++) begin
        t = v[i];
        j = i;
        while (j > 0 && v[j-1] > t) begin
          v[j] = v[j-1];
          j--;
        end
        v[j] = t;
      end
      res[ch*PW +: PW] = v[(n-1)/2];
    end
    return res;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      hs_h = '0;
      vs_h = '0;
    end else begin
      hs_h = {hs_h[2:0], hs_i};
      vs_h = {vs_h[2:0], vs_i};
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("w5 hs_o delay", 32'(hs5), 32'(hs_h[3]));
      check("w5 vs_o delay", 32'(vs5), 32'(vs_h[3]));
      check("w3 hs_o delay", 32'(hs3), 32'(hs_h[3]));
      check("w3 vs_o delay", 32'(vs3), 32'(vs_h[3]));
      if (de5) begin
        cnt5++;
        n_checks++;
        if (q5.size() == 0) begin
          n_fail++;
          $display("FAIL w5 de_o: asserted at cycle %0d, expected no output", cyc);
        end else begin
          e5 = q5.pop_front();
          check("w5 do_o", 32'(do5), 32'(e5.d));
          check("w5 bypass_o", 32'(byp5), 32'(e5.b));
          check("w5 latency", cyc, e5.cyc);
        end
      end
      if (de3) begin
        cnt3++;
        n_checks++;
        if (q3.size() == 0) begin
          n_fail++;
          $display("FAIL w3 de_o: asserted at cycle %0d, expected no output", cyc);
        end else begin
          e3 = q3.pop_front();
          check("w3 do_o", 32'(do3), 32'(e3.d));
          check("w3 bypass_o", 32'(byp3), 32'(e3.b));
          check("w3 latency", cyc, e3.cyc);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, " w5 do_o"}, 32'(do5), 32'd0);
    check({tag, " w5 bypass_o"}, 32'(byp5), 32'd0);
    check({tag, " w5 de_o"}, 32'(de5), 32'd0);
    check({tag, " w5 hs_o"}, 32'(hs5), 32'd0);
    check({tag, " w5 vs_o"}, 32'(vs5), 32'd0);
    check({tag, " w3 do_o"}, 32'(do3), 32'd0);
    check({tag, " w3 bypass_o"}, 32'(byp3), 32'd0);
    check({tag, " w3 de_o"}, 32'(de3), 32'd0);
  endtask

  task automatic run_frame(input frame_t f);
    logic [DW-1:0] pix;
    exp_t          e;
    de_i   = 1'b0;
    hs_i   = 1'b1;
    vs_i   = 1'b0;
    bypass = f.byp;
    di_i   = '0;
    cnt5   = 0;
    cnt3   = 0;
    repeat (4) @(negedge clk);
    vs_i    = 1'b1;
    no_push = 1'b0;
    repeat (3) @(negedge clk);
    for (int y = 0; y < f.h; y++) begin
      if (y == f.h / 2) bypass = ~f.byp;
      hs_i = 1'b0;
      @(negedge clk);
      for (int x = 0; x < f.w; x++) begin
        if (y == f.rst_row && x == 10) begin
          rst  = 1'b1;
          de_i = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          q5.delete();
          q3.delete();
          no_push = 1'b1;
          check_zero_outputs("mid-frame reset");
        end
        pix        = pattern(f.pat, x, y);
        img[y][x]  = pix;
        di_i       = pix;
        de_i       = 1'b1;
        if (!no_push && x < LSM) begin
          if (x >= 4 && y >= 4) begin
            e.b   = img[y-2][x-2];
            e.d   = f.byp ? e.b : med(x, y, 5);
            e.cyc = cyc + 4;
            q5.push_back(e);
          end
          if (x >= 2 && y >= 2) begin
            e.b   = img[y-1][x-1];
            e.d   = f.byp ? e.b : med(x, y, 3);
            e.cyc = cyc + 4;
            q3.push_back(e);
          end
        end
        @(negedge clk);
        de_i = 1'b0;
        repeat (f.gap) @(negedge clk);
      end
      hs_i = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    vs_i = 1'b0;
    repeat (8) @(negedge clk);
    if (f.exp5 >= 0) begin
      check("w5 de_o count per frame", cnt5, 32'(f.exp5));
      check("w3 de_o count per frame", cnt3, 32'(f.exp3));
    end
    check("w5 outputs still pending", 32'(q5.size()), 32'd0);
    check("w3 outputs still pending", 32'(q3.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  frame_t tbl[8];

  initial begin
    //         pat  w   h  gap byp rst  exp5  exp3
    tbl[0] = '{0,  64, 48, 0,  0,  -1, 2640, 2852};
    tbl[1] = '{1,  40, 30, 0,  0,  -1,  936, 1064};
    tbl[2] = '{2,  64, 48, 0,  0,  -1, 2640, 2852};
    tbl[3] = '{2,  64, 12, 3,  1,  -1,  480,  620};
    tbl[4] = '{3,  70, 10, 1,  0,  -1,  360,  496};
    tbl[5] = '{3,  16,  9, 2,  1,  -1,   60,   98};
    tbl[6] = '{3,  20, 12, 0,  0,   6,   -1,   -1};
    tbl[7] = '{3,  20, 12, 0,  0,  -1,  128,  180};

    rst    = 1'b1;
    bypass = 1'b0;
    de_i   = 1'b0;
    hs_i   = 1'b1;
    vs_i   = 1'b0;
    di_i   = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
